// File: rtl/fpu_result_rounder.sv
// Final FPU stage: normalize (stage 1), then round and pack to IEEE-754 single (stage 2).
// Define FPU_RESULT_ROUNDER_BYPASS_EN to add in_bypass for raw pass-through of moves/int results.
package fpu_result_rounder_pkg;
  typedef enum logic [1:0] {
    RND_EVEN = 2'd0,
    RND_UP   = 2'd1,
    RND_DOWN = 2'd2,
    RND_ZERO = 2'd3
  } fpu_round_mode_t;

  typedef struct packed {
    logic            sign;
    logic            nan;
    logic            inf;
    logic            zero;
    logic [2:0]      guard;
    logic [7:0]      exponent;
    logic [23:0]     mantissa;
    fpu_round_mode_t mode;
  } fpu_result_t;

  localparam logic [31:0] FPU_FLOAT_NAN = 32'hFFFFFFFF;
endpackage

module fpu_result_rounder
  import fpu_result_rounder_pkg::*;
#(
  parameter int TAG_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$bits(fpu_result_t)-1:0] in_result,
  input  logic [TAG_WIDTH-1:0]          in_tag,
`ifdef FPU_RESULT_ROUNDER_BYPASS_EN
  input  logic                          in_bypass,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_float,
  output logic [2:0]                    out_flags,
  output logic [TAG_WIDTH-1:0]          out_tag
);

  typedef struct packed {
    logic                 sign;
    logic                 nan;
    logic                 inf;
    logic                 zero;
    logic                 bypass;
    fpu_round_mode_t      mode;
    logic [7:0]           exponent;
    logic [23:0]          mantissa;
    logic [2:0]           guard;
    logic [TAG_WIDTH-1:0] tag;
  } s1_t;

  fpu_result_t          in_rec;
  logic                 bypass_in;
  logic                 s1_valid_q, s1_valid_d;
  s1_t                  s1_q, s1_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [31:0]          out_float_q, out_float_d;
  logic [2:0]           out_flags_q, out_flags_d;
  logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
  logic                 s2_advance;

  logic [7:0]  exp_eff, max_shift;
  logic [4:0]  lead_zeros, shift_amt;
  logic [26:0] norm_bits;

  logic        g, rs, lsb, inc_act, inc_near, near_carry, to_inf;
  logic        overflow, underflow, inexact;
  logic [24:0] sum_act;
  logic [23:0] rnd_mant;
  logic [8:0]  rnd_exp, near_exp;
  logic [7:0]  exp_field;
  logic [31:0] res_float;
  logic [2:0]  res_flags;

  assign in_rec = fpu_result_t'(in_result);
`ifdef FPU_RESULT_ROUNDER_BYPASS_EN
  assign bypass_in = in_bypass;
`else
  assign bypass_in = 1'b0;
`endif

  assign s2_advance = !s2_valid_q | out_ready;
  assign in_ready   = !s1_valid_q | s2_advance;

  // Stage 1: shift out leading zeros without letting the exponent drop below 1.
  always_comb begin
    exp_eff    = (in_rec.exponent == 8'd0) ? 8'd1 : in_rec.exponent;
    max_shift  = exp_eff - 8'd1;
    lead_zeros = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (in_rec.mantissa[i]) lead_zeros = 5'(23 - i);
    end
    shift_amt = ({3'd0, lead_zeros} < max_shift) ? lead_zeros : max_shift[4:0];
    if (bypass_in) shift_amt = 5'd0;
    norm_bits    = {in_rec.mantissa, in_rec.guard} << shift_amt;
    norm_bits[0] = norm_bits[0] | in_rec.guard[0];

    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_ready) s1_valid_d = in_valid;
    if (in_ready && in_valid) begin
      s1_d.sign     = in_rec.sign;
      s1_d.nan      = in_rec.nan;
      s1_d.inf      = in_rec.inf;
      s1_d.zero     = in_rec.zero;
      s1_d.bypass   = bypass_in;
      s1_d.mode     = in_rec.mode;
      s1_d.exponent = bypass_in ? in_rec.exponent : (exp_eff - {3'd0, shift_amt});
      s1_d.mantissa = norm_bits[26:3];
      s1_d.guard    = norm_bits[2:0];
      s1_d.tag      = in_tag;
    end
  end

  // Stage 2: overflow is judged on the nearest-even magnitude as well as the
  // mode's own rounding, so directed modes can still saturate to max finite.
  always_comb begin
    g        = s1_q.guard[2];
    rs       = s1_q.guard[1] | s1_q.guard[0];
    lsb      = s1_q.mantissa[0];
    inc_near = g & (rs | lsb);
    inc_act  = 1'b0;
    case (s1_q.mode)
      RND_EVEN: inc_act = inc_near;
      RND_UP:   inc_act = !s1_q.sign & (g | rs);
      RND_DOWN: inc_act = s1_q.sign & (g | rs);
      default:  inc_act = 1'b0;
    endcase
    sum_act    = {1'b0, s1_q.mantissa} + {24'd0, inc_act};
    near_carry = inc_near & (&s1_q.mantissa);
    rnd_mant   = sum_act[24] ? sum_act[24:1] : sum_act[23:0];
    rnd_exp    = {1'b0, s1_q.exponent} + {8'd0, sum_act[24]};
    near_exp   = {1'b0, s1_q.exponent} + {8'd0, near_carry};
    exp_field  = rnd_mant[23] ? rnd_exp[7:0] : 8'd0;
    overflow   = rnd_mant[23] & ((rnd_exp >= 9'd255) | (near_exp >= 9'd255));
    inexact    = g | rs | overflow;
    underflow  = inexact & !rnd_mant[23];
    to_inf     = (s1_q.mode == RND_EVEN) | ((s1_q.mode == RND_UP) & !s1_q.sign) |
                 ((s1_q.mode == RND_DOWN) & s1_q.sign);

    res_float = {s1_q.sign, exp_field, rnd_mant[22:0]};
    res_flags = {overflow, underflow, inexact};
    if (overflow) res_float = to_inf ? {s1_q.sign, 31'h7F800000} : {s1_q.sign, 31'h7F7FFFFF};
    if (s1_q.bypass) begin
      res_float = {s1_q.sign, s1_q.exponent, s1_q.mantissa[22:0]};
      res_flags = 3'b000;
    end else if (s1_q.nan) begin
      res_float = FPU_FLOAT_NAN;
      res_flags = 3'b000;
    end else if (s1_q.inf) begin
      res_float = {s1_q.sign, 31'h7F800000};
      res_flags = 3'b000;
    end else if (s1_q.zero || (s1_q.mantissa == 24'd0)) begin
      res_float = {s1_q.sign, 31'd0};
      res_flags = 3'b000;
    end

    s2_valid_d  = s2_valid_q;
    out_float_d = out_float_q;
    out_flags_d = out_flags_q;
    out_tag_d   = out_tag_q;
    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_float_d = res_float;
        out_flags_d = res_flags;
        out_tag_d   = s1_q.tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      s2_valid_q  <= 1'b0;
      out_float_q <= 32'd0;
      out_flags_q <= 3'd0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      s2_valid_q  <= s2_valid_d;
      out_float_q <= out_float_d;
      out_flags_q <= out_flags_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_float = out_float_q;
  assign out_flags = out_flags_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_fpu_result_rounder.sv
// Scoreboard bench for fpu_result_rounder: directed vectors, backpressure, reset and random traffic.
module tb_fpu_result_rounder;
  import fpu_result_rounder_pkg::*;

  localparam int TAG_WIDTH = 5;
  typedef logic [39:0] resp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  fpu_result_t          in_result;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 tb_bypass;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_float;
  logic [2:0]           out_flags;
  logic [TAG_WIDTH-1:0] out_tag;

  int    checks   = 0;
  int    errors   = 0;
  int    accepted = 0;
  resp_t exp_q[$];

  always #5 clk = ~clk;

  fpu_result_rounder #(.TAG_WIDTH(TAG_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_tag    (in_tag),
`ifdef FPU_RESULT_ROUNDER_BYPASS_EN
    .in_bypass (tb_bypass),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_float (out_float),
    .out_flags (out_flags),
    .out_tag   (out_tag)
  );

  task automatic checkOutput(input string name, input resp_t want, input resp_t got);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got float=%h flags=%b tag=%0d, required float=%h flags=%b tag=%0d",
               name, got[39:8], got[7:5], got[4:0], want[39:8], want[7:5], want[4:0]);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  function automatic fpu_result_t mk(input logic s, input logic [7:0] e, input logic [23:0] m,
                                     input logic [2:0] gd, input fpu_round_mode_t md);
    fpu_result_t r;
    r          = '0;
    r.sign     = s;
    r.exponent = e;
    r.mantissa = m;
    r.guard    = gd;
    r.mode     = md;
    return r;
  endfunction

  // Reference: value-level normalize/round on plain integers, returns {float, flags}.
  function automatic logic [34:0] model(input fpu_result_t r, input logic byp);
    longint big, m, m_near;
    int     e, e_near, ef;
    logic   g, rs, inc, inc_near, ovf, inx, to_inf;
    if (byp) return {r.sign, r.exponent, r.mantissa[22:0], 3'b000};
    if (r.nan) return {32'hFFFFFFFF, 3'b000};
    if (r.inf) return {r.sign, 31'h7F800000, 3'b000};
    if (r.zero || r.mantissa == 24'd0) return {r.sign, 31'd0, 3'b000};
    e   = (r.exponent == 8'd0) ? 1 : int'(r.exponent);
    big = longint'({r.mantissa, r.guard});
    while (e > 1 && big < (longint'(1) << 26)) begin
      big = big * 2;
      e--;
    end
    big      = big | longint'(r.guard[0]);
    g        = big[2];
    rs       = big[1] | big[0];
    m        = big >> 3;
    inc_near = g && (rs || m[0]);
    case (r.mode)
      RND_EVEN: inc = inc_near;
      RND_UP:   inc = !r.sign && (g || rs);
      RND_DOWN: inc = r.sign && (g || rs);
      default:  inc = 1'b0;
    endcase
    m_near = m + longint'(inc_near);
    e_near = (m_near == (longint'(1) << 24)) ? e + 1 : e;
    m      = m + longint'(inc);
    if (m == (longint'(1) << 24)) begin
      m = m / 2;
      e++;
    end
    ovf = (m >= (longint'(1) << 23)) && (e >= 255 || e_near >= 255);
    inx = g || rs || ovf;
    if (ovf) begin
      to_inf = (r.mode == RND_EVEN) || (r.mode == RND_UP && !r.sign) || (r.mode == RND_DOWN && r.sign);
      return {r.sign, (to_inf ? 31'h7F800000 : 31'h7F7FFFFF), 3'b101};
    end
    ef = (m >= (longint'(1) << 23)) ? e : 0;
    return {r.sign, 8'(ef), 23'(m), 1'b0, (inx && ef == 0), inx};
  endfunction

  function automatic fpu_result_t randRec();
    fpu_result_t r;
    r       = '0;
    r.sign  = 1'($urandom);
    r.nan   = ($urandom_range(0, 19) == 0);
    r.inf   = ($urandom_range(0, 19) == 0);
    r.zero  = ($urandom_range(0, 19) == 0);
    r.guard = 3'($urandom);
    case ($urandom_range(0, 7))
      0:       r.exponent = 8'd0;
      1:       r.exponent = 8'd1;
      2:       r.exponent = 8'd254;
      3:       r.exponent = 8'd255;
      default: r.exponent = 8'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0:       r.mantissa = 24'hFFFFFF;
      1:       r.mantissa = 24'($urandom) | 24'h800000;
      default: r.mantissa = 24'($urandom) >> $urandom_range(0, 24);
    endcase
    r.mode = fpu_round_mode_t'($urandom_range(0, 3));
    return r;
  endfunction

  // Called just after a rising edge; returns just after the edge that took the item.
  task automatic applyStimulus(input fpu_result_t rec, input logic byp,
                               input logic [TAG_WIDTH-1:0] tag, input resp_t want);
    int waited;
    waited    = 0;
    in_valid  = 1'b1;
    in_result = rec;
    in_tag    = tag;
    tb_bypass = byp;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
    end else begin
      exp_q.push_back(want);
      accepted++;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    tb_bypass = 1'b0;
  endtask

  task automatic drainQueue(input string name);
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    checkInt(name, exp_q.size(), 0);
  endtask

  initial begin : monitor
    resp_t held, act, want;
    logic  hold_pend;
    hold_pend = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      act = {out_float, out_flags, out_tag};
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          checkBit("hold_valid", out_valid, 1'b1);
          checkOutput("hold_stable", held, act);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got float=%h tag=%0d, required no output", out_float, out_tag);
          end else begin
            want = exp_q.pop_front();
            checkOutput("result", want, act);
          end
        end
        hold_pend = out_valid && !out_ready;
        held      = act;
      end
    end
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached, required natural completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    fpu_result_t dir_in[11];
    logic [34:0] dir_exp[11];
    fpu_result_t r;
    logic        byp;
    logic        rand_done;

    dir_in[0]  = mk(1'b0, 8'd127, 24'h800000, 3'b000, RND_EVEN); dir_exp[0]  = {32'h3F800000, 3'b000};
    dir_in[1]  = mk(1'b0, 8'd127, 24'h800001, 3'b100, RND_EVEN); dir_exp[1]  = {32'h3F800002, 3'b001};
    dir_in[2]  = mk(1'b0, 8'd127, 24'h800000, 3'b100, RND_EVEN); dir_exp[2]  = {32'h3F800000, 3'b001};
    dir_in[3]  = mk(1'b0, 8'd127, 24'hFFFFFF, 3'b110, RND_EVEN); dir_exp[3]  = {32'h40000000, 3'b001};
    dir_in[4]  = mk(1'b0, 8'd127, 24'hFFFFFF, 3'b110, RND_ZERO); dir_exp[4]  = {32'h3FFFFFFF, 3'b001};
    dir_in[5]  = mk(1'b0, 8'd254, 24'hFFFFFF, 3'b100, RND_EVEN); dir_exp[5]  = {32'h7F800000, 3'b101};
    dir_in[6]  = mk(1'b0, 8'd254, 24'hFFFFFF, 3'b100, RND_ZERO); dir_exp[6]  = {32'h7F7FFFFF, 3'b101};
    dir_in[7]  = mk(1'b1, 8'd254, 24'hFFFFFF, 3'b100, RND_UP);   dir_exp[7]  = {32'hFF7FFFFF, 3'b101};
    dir_in[8]  = mk(1'b0, 8'd127, 24'h000001, 3'b000, RND_EVEN); dir_exp[8]  = {32'h34000000, 3'b000};
    dir_in[9]  = mk(1'b0, 8'd1,   24'h400000, 3'b100, RND_ZERO); dir_exp[9]  = {32'h00400000, 3'b011};
    dir_in[10] = mk(1'b0, 8'd100, 24'h812345, 3'b010, RND_EVEN);
    dir_in[10].nan = 1'b1;                                        dir_exp[10] = {32'hFFFFFFFF, 3'b000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_tag    = '0;
    tb_bypass = 1'b0;
    out_ready = 1'b1;
    #12;
    checkBit("reset_out_valid", out_valid, 1'b0);
    checkBit("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_data", 40'd0, {out_float, out_flags, out_tag});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    in_valid  = 1'b1;
    in_result = dir_in[0];
    in_tag    = 5'd0;
    @(negedge clk);
    checkBit("first_in_ready", in_ready, 1'b1);
    exp_q.push_back({dir_exp[0], 5'd0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkBit("latency_cycle1", out_valid, 1'b0);
    @(negedge clk);
    checkBit("latency_cycle2", out_valid, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 1; i < 11; i++) applyStimulus(dir_in[i], 1'b0, 5'(i), {dir_exp[i], 5'(i)});
    drainQueue("directed_drain");

    $display("[TB] backpressure");
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    accepted  = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(dir_in[i + 1], 1'b0, 5'(20 + i), {dir_exp[i + 1], 5'(20 + i)});
      end
      begin
        repeat (6) @(negedge clk);
        checkInt("bp_accepted", accepted, 2);
        checkBit("bp_in_ready", in_ready, 1'b0);
        checkBit("bp_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drainQueue("bp_drain");
    checkInt("bp_total", accepted, 4);

    $display("[TB] reset during stall");
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(dir_in[5], 1'b0, 5'd30, {dir_exp[5], 5'd30});
    applyStimulus(dir_in[6], 1'b0, 5'd31, {dir_exp[6], 5'd31});
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkBit("midrst_out_valid", out_valid, 1'b0);
    checkBit("midrst_in_ready", in_ready, 1'b1);
    checkOutput("midrst_data", 40'd0, {out_float, out_flags, out_tag});
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkBit("post_reset_idle", out_valid, 1'b0);
    end

    $display("[TB] random traffic");
    @(posedge clk);
    #1;
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          r   = randRec();
`ifdef FPU_RESULT_ROUNDER_BYPASS_EN
          byp = ($urandom_range(0, 4) == 0);
`else
          byp = 1'b0;
`endif
          applyStimulus(r, byp, 5'(n), {model(r, byp), 5'(n)});
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drainQueue("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
